// File: rtl/rf_wb_arbiter_pkg.sv
// rf_pkg: regfile widths and the writeback request type shared by the arbiter slice.
package rf_pkg;
    localparam int RF_DATA_W   = 18;
    localparam int RF_IDX_W    = 4;
    localparam int RF_SEL_W    = 5;
    localparam int RF_NUM_REGS = 16;

    typedef struct packed {
        logic [RF_IDX_W-1:0]  addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// rf_wb_fifo: small synchronous FIFO of writeback requests.
// Per-slot occupancy and address taps feed the pending-write scoreboard.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                             clck,
    input  logic                             reset_enable,
    input  logic                             push,
    input  logic                             pop,
    input  rf_wb_req_t                       din,
    output rf_wb_req_t                       head,
    output logic                             full,
    output logic                             empty,
    output logic [DEPTH-1:0]                 occ,
    output logic [DEPTH-1:0][RF_IDX_W-1:0]   addrs
);
    localparam int PTR_W = $clog2(DEPTH);

    rf_wb_req_t       mem [DEPTH];
    logic [PTR_W-1:0] wr;
    logic [PTR_W-1:0] rd;

    assign full  = &occ;
    assign empty = ~|occ;
    assign head  = mem[rd];

    always_comb
        for (int i = 0; i < DEPTH; i++)
            addrs[i] = mem[i].addr;

    always_ff @(posedge clck)
        if (push)
            mem[wr] <= din;

    // push only when not full and pop only when not empty, so wr==rd never collides
    always_ff @(posedge clck or posedge reset_enable)
        if (reset_enable) begin
            wr  <= '0;
            rd  <= '0;
            occ <= '0;
        end else begin
            if (push) begin
                occ[wr] <= 1'b1;
                wr      <= wr + PTR_W'(1);
            end
            if (pop) begin
                occ[rd] <= 1'b0;
                rd      <= rd + PTR_W'(1);
            end
        end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges ALU (src0) and load (src1) writebacks onto the single regfile write port.
// Define RF_WB_FIXED_PRIO_EN for strict src0 priority instead of round-robin.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clck,
    input  logic                   reset_enable,
    input  logic                   src0_valid,
    output logic                   src0_ready,
    input  logic [RF_IDX_W-1:0]    src0_addr,
    input  logic [RF_DATA_W-1:0]   src0_data,
    input  logic                   src1_valid,
    output logic                   src1_ready,
    input  logic [RF_IDX_W-1:0]    src1_addr,
    input  logic [RF_DATA_W-1:0]   src1_data,
    output logic                   rf_write_enable,
    output logic [RF_SEL_W-1:0]    rf_select_register,
    output logic [RF_DATA_W-1:0]   rf_data,
    output logic [RF_NUM_REGS-1:0] pending,
    output logic                   busy
);
    logic full0, full1, empty0, empty1;
    logic push0, push1, grant0, grant1;
    logic [FIFO_DEPTH-1:0]               occ0, occ1;
    logic [FIFO_DEPTH-1:0][RF_IDX_W-1:0] addrs0, addrs1;
    rf_wb_req_t head0, head1, head;
    logic [RF_NUM_REGS-1:0] keep, set, clr;

    assign src0_ready = !full0;
    assign src1_ready = !full1;
    assign push0      = src0_valid & src0_ready;
    assign push1      = src1_valid & src1_ready;
    assign busy       = !empty0 | !empty1 | rf_write_enable;

    rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clck(clck), .reset_enable(reset_enable), .push(push0), .pop(grant0),
        .din({src0_addr, src0_data}), .head(head0), .full(full0), .empty(empty0),
        .occ(occ0), .addrs(addrs0)
    );

    rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clck(clck), .reset_enable(reset_enable), .push(push1), .pop(grant1),
        .din({src1_addr, src1_data}), .head(head1), .full(full1), .empty(empty1),
        .occ(occ1), .addrs(addrs1)
    );

`ifdef RF_WB_FIXED_PRIO_EN
    assign grant0 = !empty0;
`else
    logic rr;
    // rr=1 means src1 holds the turn; it only advances on contention
    assign grant0 = !empty0 & (empty1 | !rr);
    always_ff @(posedge clck or posedge reset_enable)
        if (reset_enable)
            rr <= 1'b0;
        else if (!empty0 & !empty1)
            rr <= grant0;
`endif
    assign grant1 = !empty1 & !grant0;
    assign head   = grant0 ? head0 : head1;

    // a commit only clears r when nothing still buffered or arriving targets r
    always_comb begin
        keep = '0;
        set  = '0;
        clr  = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (occ0[i]) keep[addrs0[i]] = 1'b1;
            if (occ1[i]) keep[addrs1[i]] = 1'b1;
        end
        if (push0) set[src0_addr] = 1'b1;
        if (push1) set[src1_addr] = 1'b1;
        if (rf_write_enable) clr[rf_select_register[RF_IDX_W-1:0]] = 1'b1;
    end

    always_ff @(posedge clck or posedge reset_enable)
        if (reset_enable) begin
            rf_write_enable    <= 1'b0;
            rf_select_register <= '0;
            rf_data            <= '0;
            pending            <= '0;
        end else begin
            rf_write_enable <= grant0 | grant1;
            if (grant0 | grant1) begin
                rf_select_register <= {1'b0, head.addr};
                rf_data            <= head.data;
            end
            pending <= (pending & ~(clr & ~keep)) | set;
        end
endmodule
